// File: rtl/core_step_ctrl.sv
// Step/run execution controller for the single-cycle core: debounced buttons, step strobe, run divider.
// Optional PC breakpoint halt is compiled in when CORE_STEP_CTRL_BREAKPOINT_EN is defined.
module core_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RUN_DIV         = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             step_en,
    output logic             running,
    output logic             halted_bp,
    output logic [CNT_W-1:0] step_count
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BP_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    // Bit 0 is the STEP button, bit 1 the RUN button.
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [1:0]      db;
    logic [1:0]      db_d;
    logic [DB_W-1:0] db_cnt [2];
    logic            step_press;
    logic            run_press;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             skip_bp;
    logic             skip_nxt;
    logic             step_nxt;

    // Synchronize both buttons and accept a new level only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
            db     <= 2'b00;
            db_d   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= {btn_run, btn_step};
            sync_b <= sync_a;
            db_d   <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign step_press = db[0] & ~db_d[0];
    assign run_press  = db[1] & ~db_d[1];

    // Next-state logic; a run press always takes priority over any step.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        skip_nxt  = skip_bp;
        step_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (run_press) begin
                    state_nxt = RUN;
                    div_nxt   = '0;
                    skip_nxt  = 1'b1;
                end else if (step_press) begin
                    step_nxt = 1'b1;
                end else begin
                    step_nxt = 1'b0;
                end
            end
            RUN: begin
                if (run_press) begin
                    state_nxt = IDLE;
                end else if (div == DIV_LAST) begin
                    div_nxt = '0;
`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
                    if (bp_valid && (pc_in == bp_addr) && !skip_bp) begin
                        state_nxt = BP_HALT;
                    end else begin
                        step_nxt = 1'b1;
                        skip_nxt = 1'b0;
                    end
`else
                    step_nxt = 1'b1;
                    skip_nxt = 1'b0;
`endif
                end else begin
                    div_nxt = div + DIV_W'(1);
                end
            end
`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
            BP_HALT: begin
                // Resuming sets skip_bp so the core can leave the breakpoint PC.
                if (run_press) begin
                    state_nxt = RUN;
                    div_nxt   = '0;
                    skip_nxt  = 1'b1;
                end else if (step_press) begin
                    state_nxt = IDLE;
                    step_nxt  = 1'b1;
                end else begin
                    state_nxt = BP_HALT;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifndef CORE_STEP_CTRL_BREAKPOINT_EN
    logic bp_unused;
    assign bp_unused = ^{bp_valid, bp_addr, pc_in, skip_bp};
`endif

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            skip_bp    <= 1'b0;
            step_en    <= 1'b0;
            running    <= 1'b0;
            halted_bp  <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            skip_bp    <= skip_nxt;
            step_en    <= step_nxt;
            running    <= (state_nxt == RUN);
`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
            halted_bp  <= (state_nxt == BP_HALT);
`else
            halted_bp  <= 1'b0;
`endif
            step_count <= step_count + CNT_W'(step_nxt);
        end
    end

endmodule

// File: tb/tb_core_step_ctrl.sv
// Self-checking bench for core_step_ctrl: cycle model of the button/step rules plus directed
// literal checks; a second instance with RUN_DIV=1 exercises the 16-bit step_count wrap.
module tb_core_step_ctrl;

    localparam int D  = 4;
    localparam int RD = 3;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          btn_step;
    logic          btn_run;
    logic [31:0]   pc_in;
    logic [31:0]   bp_addr;
    logic          bp_valid;
    logic          pc_clr;
    logic          step_en;
    logic          running;
    logic          halted_bp;
    logic [CW-1:0] step_count;

    logic          w_rst;
    logic          w_run;
    logic          w_step_en;
    logic          w_running;
    logic          w_halted;
    logic [15:0]   w_count;
    logic          wrap_done;

    int n_cmp  = 0;
    int n_fail = 0;

    core_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(RD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
        .pc_in(pc_in), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .step_en(step_en), .running(running), .halted_bp(halted_bp),
        .step_count(step_count)
    );

    core_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(1), .CNT_W(16)) u_wrap (
        .clk(clk), .rst(w_rst), .btn_step(1'b0), .btn_run(w_run),
        .pc_in(32'd0), .bp_addr(32'd0), .bp_valid(1'b0),
        .step_en(w_step_en), .running(w_running), .halted_bp(w_halted),
        .step_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the core PC register: advances by 4 on every step strobe.
    always @(posedge clk) begin
        if (pc_clr) pc_in <= 32'd0;
        else if (step_en) pc_in <= pc_in + 32'd4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // A button level is accepted once the synchronized samples (raw delayed two edges) have
    // differed from the current level for D consecutive edges; a rise is a press that the
    // controller acts on one edge later.
    bit            m_h [2][D+2];
    bit            m_db [2];
    bit            m_rose [2];
    bit            m_raw [2];
    bit            m_stable;
    bit            m_sp;
    bit            m_rp;
    bit            m_bphit;
    bit            m_en;
    bit            m_skip;
    int            m_state;   // 0 idle, 1 running, 2 halted on breakpoint
    int            m_div;
    logic [CW-1:0] m_cnt = '0;

    initial begin
        forever begin
            @(posedge clk);
            m_raw[0] = btn_step;
            m_raw[1] = btn_run;
            m_sp = m_rose[0];
            m_rp = m_rose[1];
`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
            m_bphit = bp_valid && (pc_in == bp_addr);
`else
            m_bphit = 1'b0;
`endif
            for (int b = 0; b < 2; b++) begin
                for (int k = D + 1; k > 0; k--) m_h[b][k] = m_h[b][k-1];
                m_h[b][0] = m_raw[b];
                m_stable = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (m_h[b][k] == m_db[b]) m_stable = 1'b0;
                m_rose[b] = m_stable && !m_db[b];
                if (m_stable) m_db[b] = !m_db[b];
            end
            if (rst) begin
                for (int b = 0; b < 2; b++) begin
                    for (int k = 0; k < D + 2; k++) m_h[b][k] = 1'b0;
                    m_db[b]   = 1'b0;
                    m_rose[b] = 1'b0;
                end
                m_state = 0; m_div = 0; m_skip = 1'b0; m_en = 1'b0; m_cnt = '0;
            end else begin
                m_en = 1'b0;
                if (m_rp) begin
                    if (m_state == 1) m_state = 0;
                    else begin m_state = 1; m_div = 0; m_skip = 1'b1; end
                end else if (m_state == 1) begin
                    if (m_div == RD - 1) begin
                        m_div = 0;
                        if (m_bphit && !m_skip) m_state = 2;
                        else begin m_en = 1'b1; m_skip = 1'b0; end
                    end else begin
                        m_div = m_div + 1;
                    end
                end else if (m_sp) begin
                    m_en = 1'b1;
                    m_state = 0;
                end
                if (m_en) m_cnt = m_cnt + 1'b1;
            end
            #1;
            check("step_en", step_en, m_en);
            check("running", running, m_state == 1);
            check("halted_bp", halted_bp, m_state == 2);
            check("step_count", step_count, m_cnt);
        end
    end

    // ---------------- wrap instance: continuous run past 16'hFFFF ----------------
    initial begin
        wrap_done = 1'b0;
        w_rst = 1'b1;
        w_run = 1'b0;
        tick(3);
        w_rst = 1'b0;
        w_run = 1'b1;
        for (int e = 1; e <= 7 + 65537; e++) begin
            @(posedge clk);
            #2;
            if (e == 20) w_run = 1'b0;
            if (e == 7) begin
                check("wrap_enter_running", w_running, 1'b1);
                check("wrap_enter_no_step", w_step_en, 1'b0);
                check("wrap_enter_count", w_count, 16'd0);
            end
            if (e == 7 + 65535) check("wrap_ffff", w_count, 16'hFFFF);
            if (e == 7 + 65536) begin
                check("wrap_zero", w_count, 16'h0000);
                check("wrap_step", w_step_en, 1'b1);
            end
            if (e == 7 + 65537) check("wrap_one", w_count, 16'h0001);
        end
        wrap_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [CW-1:0] base;
    bit            found;

    initial begin
        rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0;
        bp_valid = 1'b0; bp_addr = 32'd0; pc_clr = 1'b1;
        tick(3);
        rst = 1'b0; pc_clr = 1'b0;
        tick(2);
        check("reset_count", step_count, 16'd0);
        check("reset_running", running, 1'b0);

        // Debounce latency: step_en only between edges 7 and 8.
        btn_step = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #2;
            check("latency", step_en, (e == 7));
        end
        check("first_count", step_count, 16'd1);
        btn_step = 1'b0;
        tick(10);

        // Two-cycle glitch is rejected.
        btn_step = 1'b1; tick(2); btn_step = 1'b0; tick(15);
        check("glitch_count", step_count, 16'd1);

        for (int i = 0; i < 3; i++) begin
            btn_step = 1'b1; tick(10); btn_step = 1'b0; tick(10);
        end
        check("three_steps", step_count, 16'd4);

        btn_step = 1'b1; tick(100); btn_step = 1'b0; tick(10);
        check("hold_one_pulse", step_count, 16'd5);

        // Run for 30 cycles at RUN_DIV=3: steps 3,6,...,27 cycles after entry.
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(22);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(12);
        check("run_count", step_count, 16'd14);
        check("run_stopped", running, 1'b0);

        // Breakpoint at 0x10 with the PC starting at 0.
        pc_clr = 1'b1; tick(1); pc_clr = 1'b0;
        bp_addr = 32'h10; bp_valid = 1'b1;
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(30);
`ifdef CORE_STEP_CTRL_BREAKPOINT_EN
        check("bp_halted", halted_bp, 1'b1);
        check("bp_not_running", running, 1'b0);
        check("bp_pc", pc_in, 32'h10);
        check("bp_count", step_count, 16'd18);

        btn_step = 1'b1; tick(8); btn_step = 1'b0; tick(10);
        check("halt_step_idle", halted_bp, 1'b0);
        check("halt_step_count", step_count, 16'd19);
        check("halt_step_pc", pc_in, 32'h14);

        bp_addr = 32'h1C;
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(30);
        check("bp2_halted", halted_bp, 1'b1);
        check("bp2_count", step_count, 16'd21);
        check("bp2_pc", pc_in, 32'h1C);

        btn_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (step_en) begin found = 1'b1; break; end
        end
        check("resume_found", found, 1'b1);
        check("resume_pc", pc_in, 32'h1C);
        check("resume_count", step_count, 16'd22);
        btn_run = 1'b0; tick(10);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        check("resume_stopped", running, 1'b0);
        check("resume_not_halted", halted_bp, 1'b0);
`else
        check("nobp_not_halted", halted_bp, 1'b0);
        check("nobp_running", running, 1'b1);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        check("nobp_stopped", running, 1'b0);
`endif
        bp_valid = 1'b0;

        // Simultaneous step and run press from IDLE: run wins.
        base = m_cnt;
        btn_step = 1'b1; btn_run = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #2;
            if (e == 7) begin
                check("simul_running", running, 1'b1);
                check("simul_no_step", step_en, 1'b0);
            end
            if (e == 9) check("simul_count", step_count, base);
        end
        btn_step = 1'b0; btn_run = 1'b0; tick(10);
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        check("simul_stopped", running, 1'b0);

        // Reset in the middle of a run.
        btn_run = 1'b1; tick(8); btn_run = 1'b0; tick(10);
        check("pre_reset_running", running, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("rst_step_en", step_en, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_halted", halted_bp, 1'b0);
        check("rst_count", step_count, 16'd0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("post_reset_idle", running, 1'b0);
        check("post_reset_count", step_count, 16'd0);

        wait (wrap_done);
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_step_ctrl.md
Name: core_step_ctrl

Overview:
Execution controller that sits directly upstream of the single-cycle RISC-V core and gates its state updates.
- Debounces the board STEP and RUN pushbuttons.
- Emits a one-cycle step_en strobe. The core uses it as load enable for the PC register, register-file write and data-memory write.
- Supports single-step mode, free-run mode at a divided rate, and a PC breakpoint halt.
- Exports a step counter for the LED/seven-segment display mux.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles required before a button level is accepted; minimum 2.
- RUN_DIV, 1: in RUN, one step_en every RUN_DIV clk cycles; 1 means continuous.
- CNT_W, 16: width of step_count.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset.
- btn_step, in, 1: raw, asynchronous STEP pushbutton.
- btn_run, in, 1: raw, asynchronous RUN/STOP toggle pushbutton.
- pc_in, in, 32: current core PC (PC register output).
- bp_addr, in, 32: breakpoint address.
- bp_valid, in, 1: breakpoint armed.
- step_en, out, 1: one-cycle advance strobe to the core.
- running, out, 1: 1 while in RUN state.
- halted_bp, out, 1: 1 while stopped on a breakpoint.
- step_count, out, CNT_W: number of step_en pulses issued, wrapping.

Behaviour:
- Reset: rst is synchronous, active-high. On an edge with rst=1:
  - synchronizers, debounce counters and debounced levels go to 0;
  - FSM goes to IDLE;
  - step_en=0, running=0, halted_bp=0, step_count=0, run divider=0.
  - Reset mid-debounce or mid-run discards all progress.
- Synchronizer: each button passes through a 2-FF synchronizer; its output is s.
- Debounce (per button): registers db and cnt.
  - At each edge with s!=db: if cnt==DEBOUNCE_CYCLES-1, then db<=s and cnt<=0; else cnt<=cnt+1.
  - At each edge with s==db: cnt<=0. Any glitch therefore restarts the count.
  - Press event = db rising. Falling edges generate no event.
- Latency: raw btn_step first sampled high at edge 1 and held → db high after edge D+2 → step_en high after edge D+3, low after edge D+4. Here D=DEBOUNCE_CYCLES.
- FSM states: IDLE, RUN, BP_HALT. step_en and all outputs are registered.
  - IDLE:
    - step press → step_en=1 for one cycle; stay IDLE.
    - run press → RUN; divider cleared; skip_bp=1.
  - RUN:
    - divider counts 0..RUN_DIV-1; at terminal count, a step is due.
    - If a step is due and bp_valid=1 and pc_in==bp_addr and skip_bp=0: no step_en; go to BP_HALT.
    - Otherwise a due step produces step_en=1 and clears skip_bp.
    - step press is ignored.
    - run press → IDLE with no step_en that cycle. Run press has priority over a due step in the same cycle.
  - BP_HALT:
    - halted_bp=1.
    - step press → one step_en; go to IDLE.
    - run press → RUN with skip_bp=1, so the core leaves the breakpoint PC.
- Simultaneous step and run press: the run press wins and the step press is dropped, in every state.
- running=1 exactly while in RUN. halted_bp=1 exactly while in BP_HALT.
- step_count increments by 1 on every cycle step_en=1. It wraps from all-ones to 0.
- The breakpoint compare uses the full 32-bit pc_in. It is sampled in the same cycle the step is due.

Optional Feature:
- Macro: CORE_STEP_CTRL_BREAKPOINT_EN.
- Defined: breakpoint logic as described above.
- Undefined:
  - no comparator and no BP_HALT state;
  - bp_addr and bp_valid are ignored;
  - halted_bp is tied to 0;
  - RUN continues until a run press.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=3, breakpoint feature defined):
- Reset → assert rst 2 cycles mid-run → step_en=0, running=0, halted_bp=0, step_count=0 on the first edge after rst.
- Debounce → btn_step high from edge 1 → step_en high only between edges 7 and 8; step_count=1. A 2-cycle btn_step glitch → no step_en.
- Single steps → 3 clean step presses → exactly 3 step_en pulses; step_count=3. Holding btn_step 100 cycles gives 1 pulse.
- Run mode → run press, hold 30 cycles, run press → step_en every 3rd cycle while running=1 (10 pulses ±1); running returns to 0; no step_en after stop.
- Breakpoint → bp_addr=32'h10, bp_valid=1, pc_in advanced by 4 per step_en starting at 0 → 4 steps, then halted_bp=1, running=0, pc_in=32'h10. A run press resumes with the first step_en issued at pc_in=32'h10.
- Wrap and simultaneous press → preload via 65535 steps, then one more → step_count=0. Step and run pressed on the same cycle from IDLE → RUN entered; no single-step pulse.
